// File: rtl/divider_pkg.sv
// Shared types and constants for the restoring divider.
package divider_pkg;

   localparam int DIVIDER_BITS = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Step counter width; BITS=2 still needs one bit to count 1 down to 0.
   function automatic int step_width(input int bits);
      return (bits > 2) ? $clog2(bits) : 1;
   endfunction

endpackage

// File: rtl/divider_step.sv
// One restoring-division iteration: shift in the next dividend bit, compare, conditionally subtract.
module divider_step
   import divider_pkg::*;
#(
   parameter int BITS = DIVIDER_BITS
) (
   input  logic [BITS:0]   rem_in,
   input  logic            dividend_bit,
   input  logic [BITS-1:0] divisor,
   output logic [BITS:0]   rem_out,
   output logic            quotient_bit
);

   logic [BITS:0] shifted_s;
   logic [BITS:0] divisor_ext_s;
   logic          take_s;

   // A set top bit means the shifted value would exceed any divisor, so it forces a subtract.
   always_comb begin
      shifted_s     = {rem_in[BITS-1:0], dividend_bit};
      divisor_ext_s = {1'b0, divisor};
      take_s        = rem_in[BITS] | (shifted_s >= divisor_ext_s);
      if (take_s) begin
         rem_out      = shifted_s - divisor_ext_s;
         quotient_bit = 1'b1;
      end else begin
         rem_out      = shifted_s;
         quotient_bit = 1'b0;
      end
   end

endmodule

// File: rtl/divider.sv
// Unsigned restoring divider, one quotient bit per cycle, MSB first.
// Optional o_div_by_zero output is built when DIVIDER_ZERO_FLAG_EN is defined.
module divider
   import divider_pkg::*;
#(
   parameter int BITS = DIVIDER_BITS
) (
   input  logic            i_clock,
   input  logic            i_reset,
   input  logic            i_start,
   input  logic [BITS-1:0] i_dividend,
   input  logic [BITS-1:0] i_divisor,
   output logic [BITS-1:0] o_quotient,
   output logic [BITS-1:0] o_remainder,
   output logic            o_busy,
   output logic            o_finished
`ifdef DIVIDER_ZERO_FLAG_EN
   ,
   output logic            o_div_by_zero
`endif
);

   localparam int              CW        = step_width(BITS);
   localparam logic [CW-1:0]   LAST_STEP = CW'(BITS - 1);
   localparam logic [CW-1:0]   ZERO_STEP = CW'(0);
   localparam logic [CW-1:0]   ONE_STEP  = CW'(1);

   state_t            state_r;
   state_t            state_s;
   logic [CW-1:0]     step_r;
   logic [BITS:0]     rem_r;
   logic [BITS-1:0]   work_r;
   logic [BITS-1:0]   divisor_r;
   logic [BITS:0]     step_rem_s;
   logic              step_q_s;
   logic              accept_s;
   logic              last_s;

   // work_r starts as the dividend and shifts left; quotient bits fill in from the LSB.
   divider_step #(
      .BITS (BITS)
   ) u_step (
      .rem_in       (rem_r),
      .dividend_bit (work_r[BITS-1]),
      .divisor      (divisor_r),
      .rem_out      (step_rem_s),
      .quotient_bit (step_q_s)
   );

   // Next-state decode.
   always_comb begin
      state_s  = state_r;
      accept_s = 1'b0;
      last_s   = 1'b0;
      case (state_r)
         IDLE: begin
            if (i_start) begin
               state_s  = RUN;
               accept_s = 1'b1;
            end else begin
               state_s  = IDLE;
            end
         end
         RUN: begin
            if (step_r == ZERO_STEP) begin
               state_s = DONE;
               last_s  = 1'b1;
            end else begin
               state_s = RUN;
            end
         end
         DONE: begin
            state_s = IDLE;
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // State, status flags and datapath registers.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         state_r     <= IDLE;
         step_r      <= ZERO_STEP;
         rem_r       <= {(BITS + 1){1'b0}};
         work_r      <= {BITS{1'b0}};
         divisor_r   <= {BITS{1'b0}};
         o_quotient  <= {BITS{1'b0}};
         o_remainder <= {BITS{1'b0}};
         o_busy      <= 1'b0;
         o_finished  <= 1'b0;
      end else begin
         state_r    <= state_s;
         o_busy     <= (state_s != IDLE);
         o_finished <= (state_s == DONE);
         if (accept_s) begin
            step_r    <= LAST_STEP;
            rem_r     <= {(BITS + 1){1'b0}};
            work_r    <= i_dividend;
            divisor_r <= i_divisor;
         end else if (state_r == RUN) begin
            rem_r  <= step_rem_s;
            work_r <= {work_r[BITS-2:0], step_q_s};
            if (last_s) begin
               step_r      <= ZERO_STEP;
               o_quotient  <= {work_r[BITS-2:0], step_q_s};
               o_remainder <= step_rem_s[BITS-1:0];
            end else begin
               step_r      <= step_r - ONE_STEP;
            end
         end else begin
            step_r <= step_r;
         end
      end
   end

`ifdef DIVIDER_ZERO_FLAG_EN
   // Zero-divisor flag captured with the operands and held alongside the results.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         o_div_by_zero <= 1'b0;
      end else if (accept_s) begin
         o_div_by_zero <= (i_divisor == {BITS{1'b0}});
      end else begin
         o_div_by_zero <= o_div_by_zero;
      end
   end
`endif

endmodule
